// File: rtl/ram_1024x8_pkg.sv
// Shared constants for the 1024x8 simple dual-port RAM.
package ram_1024x8_pkg;

    localparam int RAM_ADDR_WIDTH = 10;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_DEPTH      = 1024;

endpackage : ram_1024x8_pkg

// File: rtl/ram_1024x8_array.sv
// Storage array of the simple dual-port RAM: synchronous write on wr_clk,
// combinational (unregistered) read. The array is deliberately left without
// any reset or initialisation so it maps onto plain block RAM.
module ram_1024x8_array
    import ram_1024x8_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_word
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Whole-word write on the rising write clock; no byte enables.
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous array read; the top level registers it on rd_clk.
    assign rd_word = mem_r[rd_addr];

endmodule : ram_1024x8_array

// File: rtl/ram_1024x8.sv
// Simple dual-port RAM, 1024 x 8 at default parameters, independent write and
// read clocks. Read latency is one rd_clk cycle through a single output
// register. Because the array write is non-blocking and the read register
// samples the combinational array output, tying the clocks together gives
// read-first behaviour on a same-address collision.
module ram_1024x8
    import ram_1024x8_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic                  wr_en_gated_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Writes are blocked while the write domain is in reset; memory is kept.
    always_comb begin
        wr_en_gated_s = 1'b0;
        if (tb_wr_rst) begin
            wr_en_gated_s = 1'b0;
        end else begin
            wr_en_gated_s = wr_en;
        end
    end

    ram_1024x8_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .wr_clk  (wr_clk),
        .wr_en   (wr_en_gated_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_word (rd_word_s)
    );

    // Read data register: cleared at once by rd_rst, otherwise loads every rd_clk.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_r <= rd_word_s;
        end
    end

    assign rd_data = rd_data_r;

endmodule : ram_1024x8

// File: tb/tb_ram_1024x8.sv
// Self-checking bench for ram_1024x8: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_ram_1024x8;

    logic       wr_clk      = 1'b0;
    logic       rd_clk_free = 1'b0;
    logic       tie_clks    = 1'b1;
    logic       rd_clk;
    logic       tb_wr_rst   = 1'b0;
    logic       rd_rst      = 1'b0;
    logic       wr_en       = 1'b0;
    logic [9:0] wr_addr     = 10'd0;
    logic [7:0] wr_data     = 8'd0;
    logic [9:0] rd_addr     = 10'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain array plus the word expected on rd_data.
    logic [7:0] model_mem [0:1023];
    logic [7:0] exp_q;

    always #5 wr_clk = ~wr_clk;
    always #7 rd_clk_free = ~rd_clk_free;
    assign rd_clk = tie_clks ? wr_clk : rd_clk_free;

    ram_1024x8 dut (
        .wr_clk    (wr_clk),
        .tb_wr_rst (tb_wr_rst),
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Model memory: a write lands when enabled and not in write reset.
    always @(posedge wr_clk) begin
        if (wr_en && !tb_wr_rst) model_mem[wr_addr] <= wr_data;
    end

    // Model read data: old contents on each read edge, zero during read reset.
    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) exp_q <= 8'h00;
        else        exp_q <= model_mem[rd_addr];
    end

    function automatic logic [7:0] pattern(input int n);
        int v;
        v = (256 - (n % 256)) % 256;
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: rd_data=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge rd_clk);
            if (!$isunknown(exp_q)) check("model", rd_data, exp_q);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[9:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        fork
            compare_loop();
        join_none

        // Reset: both resets high, write pulses must be ignored.
        #1;
        tb_wr_rst = 1'b1;
        rd_rst    = 1'b1;
        #1;
        check("reset_rd_data", rd_data, 8'h00);
        for (int i = 0; i < 5; i++) write_word(i, 8'hC3);
        #150;
        check("reset_hold", rd_data, 8'h00);
        tick();
        tb_wr_rst = 1'b0;
        rd_rst    = 1'b0;

        // Full write: 1..1023 then 0, addr n gets (256-n) mod 256.
        for (int n = 1; n < 1024; n++) write_word(n, pattern(n));
        write_word(0, pattern(0));

        // Full read back-to-back; the compare process checks every word.
        for (int n = 1; n < 1024; n++) begin
            rd_addr = n[9:0];
            tick();
        end
        rd_addr = 10'd0;
        tick();
        check("full_read_addr0", rd_data, 8'h00);

        // Latency: addr 1 then addr 2 on consecutive edges.
        rd_addr = 10'd1;
        tick();
        check("latency_k", rd_data, 8'hFF);
        rd_addr = 10'd2;
        tick();
        check("latency_k1", rd_data, 8'hFE);

        // Boundaries.
        write_word(0, 8'hA5);
        write_word(1023, 8'h5A);
        rd_addr = 10'd0;    tick(); check("bound_0", rd_data, 8'hA5);
        rd_addr = 10'd1023; tick(); check("bound_1023", rd_data, 8'h5A);
        rd_addr = 10'd1;    tick(); check("bound_1", rd_data, 8'hFF);
        rd_addr = 10'd1022; tick(); check("bound_1022", rd_data, 8'h02);

        // Collision with tied clocks: read-first, then new value.
        write_word(7, 8'h11);
        rd_addr = 10'd7;
        write_word(7, 8'h33);
        check("collide_old", rd_data, 8'h11);
        tick();
        check("collide_new", rd_data, 8'h33);

        // Write reset blocks writes and keeps memory.
        tb_wr_rst = 1'b1;
        for (int i = 0; i < 4; i++) write_word(10, 8'h00);
        tb_wr_rst = 1'b0;
        rd_addr = 10'd10;
        tick();
        check("wr_rst_retain", rd_data, 8'hF6);

        // Read reset in the middle of a burst.
        for (int n = 20; n < 26; n++) begin
            rd_addr = n[9:0];
            tick();
        end
        #2;
        rd_rst = 1'b1;
        #1;
        check("rd_rst_immediate", rd_data, 8'h00);
        tick();
        check("rd_rst_hold", rd_data, 8'h00);
        rd_rst  = 1'b0;
        rd_addr = 10'd30;
        #1;
        check("rd_rst_after_release", rd_data, 8'h00);
        tick();
        check("rd_rst_read30", rd_data, 8'hE2);

        // Randomized traffic with tied clocks, collisions included.
        for (int i = 0; i < 600; i++) begin
            r       = $urandom;
            wr_en   = r[0];
            wr_addr = r[10:1];
            wr_data = r[18:11];
            if (r[19]) rd_addr = r[10:1];
            else begin
                r       = $urandom;
                rd_addr = r[9:0];
            end
            tick();
        end
        wr_en = 1'b0;

        // Asynchronous clocks: writes to upper half, reads from lower half.
        @(negedge wr_clk);
        tie_clks = 1'b0;
        fork
            begin
                int unsigned rw;
                for (int i = 0; i < 400; i++) begin
                    rw      = $urandom;
                    wr_en   = rw[0];
                    wr_addr = {1'b1, rw[9:1]};
                    wr_data = rw[17:10];
                    @(posedge wr_clk);
                    #1;
                end
                wr_en = 1'b0;
            end
            begin
                int unsigned rr;
                for (int i = 0; i < 300; i++) begin
                    rr      = $urandom;
                    rd_addr = {1'b0, rr[8:0]};
                    @(posedge rd_clk);
                    #1;
                end
            end
        join

        @(posedge rd_clk);
        @(negedge rd_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ram_1024x8
